// File: rtl/button_input_pkg.sv
// Shared definitions for the debounced push-button input block:
// per-channel FSM state encoding and the default debounce interval.
package button_input_pkg;

    typedef enum logic [1:0] {
        REL    = 2'd0,
        WAIT_P = 2'd1,
        PRS    = 2'd2,
        WAIT_R = 2'd3
    } db_state_e;

    // 10 ms at 27 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 270000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, polarity normalisation and a
// debounce FSM producing a clean level plus one-cycle press/release pulses.
module debounce_channel
    import button_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);

    localparam int            CW           = $clog2(DEBOUNCE_CYCLES);
    localparam logic          RAW_RELEASED = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic [CW-1:0] TERMINAL     = CW'(DEBOUNCE_CYCLES - 1);

    logic      sync1_q;
    logic      sync2_q;
    logic      pressed;
    db_state_e state_q;
    logic [CW-1:0] cnt_q;
    logic      level_q;
    logic      press_q;
    logic      release_q;

    // Synchronizer resets to the released pad value so reset never looks like a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= RAW_RELEASED;
            sync2_q <= RAW_RELEASED;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= REL;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                REL: begin
                    if (pressed) begin
                        state_q <= WAIT_P;
                        cnt_q   <= '0;
                    end
                end
                WAIT_P: begin
                    if (!pressed) begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end else if (cnt_q == TERMINAL) begin
                        state_q <= PRS;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                PRS: begin
                    if (!pressed) begin
                        state_q <= WAIT_R;
                        cnt_q   <= '0;
                    end
                end
                WAIT_R: begin
                    if (pressed) begin
                        state_q <= PRS;
                        cnt_q   <= '0;
                    end else if (cnt_q == TERMINAL) begin
                        state_q   <= REL;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= REL;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/button_input.sv
// Debounced button bank: one debounce_channel per button plus sticky press
// flags that software reads through event_status and clears by mask.
module button_input
    import button_input_pkg::*;
#(
    parameter int NUM_BUTTONS     = 2,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [31:0]            event_status,
    input  logic                   event_clear,
    input  logic [NUM_BUTTONS-1:0] event_clear_mask
);

    logic [NUM_BUTTONS-1:0] flags_q;
    logic [NUM_BUTTONS-1:0] flags_d;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .raw_i     (btn_raw[i]),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i])
        );
    end

    // A press arriving on the same edge as a clear keeps its flag set.
    assign flags_d = (flags_q & ~({NUM_BUTTONS{event_clear}} & event_clear_mask)) | btn_press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign event_status = {{(32 - NUM_BUTTONS){1'b0}}, flags_q};

endmodule

// File: tb/tb_button_input.sv
// Self-checking bench for button_input: directed scenarios plus randomized
// bouncing buttons and clears, compared against a stability-count model.
module tb_button_input;

    localparam int NB = 2;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [31:0]   event_status;
    logic          event_clear;
    logic [NB-1:0] event_clear_mask;

    int vectors     = 0;
    int miscompares = 0;

    logic [NB-1:0] mLevel;
    logic [NB-1:0] mPress;
    logic [NB-1:0] mRelease;
    logic [31:0]   mStatus;
    logic [NB-1:0] mPressed;
    logic [NB-1:0] mClearBits;
    logic [NB-1:0] rawHist[$];
    int            streak[NB];
    int            holdLeft[NB];

    button_input #(
        .NUM_BUTTONS     (NB),
        .DEBOUNCE_CYCLES (DB),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .btn_raw          (btn_raw),
        .btn_level        (btn_level),
        .btn_press        (btn_press),
        .btn_release      (btn_release),
        .event_status     (event_status),
        .event_clear      (event_clear),
        .event_clear_mask (event_clear_mask)
    );

    always #5 clk = ~clk;

    // Reference: the FSM sees the pad value from two edges ago; a level change is
    // accepted once that value has disagreed with the level on DB+1 consecutive edges.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mLevel   = '0;
            mPress   = '0;
            mRelease = '0;
            mStatus  = '0;
            for (int i = 0; i < NB; i++) streak[i] = 0;
            rawHist.delete();
            rawHist.push_back('1);
            rawHist.push_back('1);
        end else begin
            mPressed = ~rawHist.pop_front();
            rawHist.push_back(btn_raw);
            mClearBits = event_clear ? event_clear_mask : '0;
            mStatus[NB-1:0] = (mStatus[NB-1:0] & ~mClearBits) | mPress;
            mPress   = '0;
            mRelease = '0;
            for (int i = 0; i < NB; i++) begin
                if (mPressed[i] != mLevel[i]) streak[i] = streak[i] + 1;
                else streak[i] = 0;
                if (streak[i] == DB + 1) begin
                    mLevel[i] = mPressed[i];
                    if (mPressed[i]) mPress[i] = 1'b1;
                    else mRelease[i] = 1'b1;
                    streak[i] = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        btn_raw = 2'b11;
        event_clear = 1'b0;
        event_clear_mask = '0;
        repeat (3) tick();
        vectors++;
        if ({btn_level, btn_press, btn_release, event_status} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_held: got lvl=%b prs=%b rel=%b st=%h, want all 0",
                     btn_level, btn_press, btn_release, event_status);
        end
        rst = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            vectors++;
            if ({btn_level, btn_press, btn_release, event_status} !== '0) begin
                miscompares++;
                $display("[TB] FAIL reset_quiet cycle %0d: got lvl=%b prs=%b rel=%b st=%h, want all 0",
                         k, btn_level, btn_press, btn_release, event_status);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [33:0] want;
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            want = {(k >= 11) ? 1'b1 : 1'b0, (k == 11) ? 1'b1 : 1'b0, (k >= 12) ? 32'h1 : 32'h0};
            vectors++;
            if ({btn_level[0], btn_press[0], event_status} !== want) begin
                miscompares++;
                $display("[TB] FAIL clean_press cycle %0d: got lvl=%b prs=%b st=%h, want %h",
                         k, btn_level[0], btn_press[0], event_status, want);
            end
            vectors++;
            if ({btn_level, btn_press, btn_release, event_status} !== {mLevel, mPress, mRelease, mStatus}) begin
                miscompares++;
                $display("[TB] FAIL model_press cycle %0d: got %b %b %b %h, want %b %b %b %h", k,
                         btn_level, btn_press, btn_release, event_status, mLevel, mPress, mRelease, mStatus);
            end
        end
    endtask

    task automatic test_release();
        logic [33:0] want;
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            want = {(k < 11) ? 1'b1 : 1'b0, (k == 11) ? 1'b1 : 1'b0, 32'h1};
            vectors++;
            if ({btn_level[0], btn_release[0], event_status} !== want) begin
                miscompares++;
                $display("[TB] FAIL release cycle %0d: got lvl=%b rel=%b st=%h, want %h",
                         k, btn_level[0], btn_release[0], event_status, want);
            end
            vectors++;
            if ({btn_level, btn_press, btn_release, event_status} !== {mLevel, mPress, mRelease, mStatus}) begin
                miscompares++;
                $display("[TB] FAIL model_release cycle %0d: got %b %b %b %h, want %b %b %b %h", k,
                         btn_level, btn_press, btn_release, event_status, mLevel, mPress, mRelease, mStatus);
            end
        end
    endtask

    task automatic test_bounce();
        for (int k = 1; k <= 20; k++) begin
            if (k == 1) btn_raw[0] = 1'b0;
            if (k == 6) btn_raw[0] = 1'b1;
            if (k == 8) btn_raw[0] = 1'b0;
            tick();
            vectors++;
            if (btn_press[0] !== ((k == 18) ? 1'b1 : 1'b0)) begin
                miscompares++;
                $display("[TB] FAIL bounce_press cycle %0d: got %b, want %b", k, btn_press[0], (k == 18));
            end
            vectors++;
            if ({btn_level, btn_press, btn_release, event_status} !== {mLevel, mPress, mRelease, mStatus}) begin
                miscompares++;
                $display("[TB] FAIL model_bounce cycle %0d: got %b %b %b %h, want %b %b %b %h", k,
                         btn_level, btn_press, btn_release, event_status, mLevel, mPress, mRelease, mStatus);
            end
        end
    endtask

    task automatic test_clear();
        btn_raw[1] = 1'b0;
        repeat (12) tick();
        vectors++;
        if (event_status !== 32'h3) begin
            miscompares++;
            $display("[TB] FAIL clear_setup: got %h, want 00000003", event_status);
        end
        event_clear = 1'b1;
        event_clear_mask = 2'b01;
        tick();
        event_clear = 1'b0;
        vectors++;
        if (event_status !== 32'h2) begin
            miscompares++;
            $display("[TB] FAIL clear_mask01: got %h, want 00000002", event_status);
        end
        btn_raw[1] = 1'b1;
        repeat (12) tick();
        event_clear = 1'b1;
        event_clear_mask = 2'b11;
        tick();
        event_clear = 1'b0;
        vectors++;
        if (event_status !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL clear_all: got %h, want 00000000", event_status);
        end
        btn_raw[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            event_clear = 1'b0;
            if (k == 11) begin
                vectors++;
                if (btn_press !== 2'b10) begin
                    miscompares++;
                    $display("[TB] FAIL clear_race_pulse: got %b, want 10", btn_press);
                end
                event_clear = 1'b1;
                event_clear_mask = 2'b10;
            end
        end
        vectors++;
        if (event_status !== 32'h2) begin
            miscompares++;
            $display("[TB] FAIL clear_set_wins: got %h, want 00000002", event_status);
        end
        vectors++;
        if ({btn_level, btn_press, btn_release, event_status} !== {mLevel, mPress, mRelease, mStatus}) begin
            miscompares++;
            $display("[TB] FAIL model_clear: got %b %b %b %h, want %b %b %b %h",
                     btn_level, btn_press, btn_release, event_status, mLevel, mPress, mRelease, mStatus);
        end
    endtask

    task automatic test_reset_mid();
        btn_raw[0] = 1'b1;
        repeat (12) tick();
        btn_raw[0] = 1'b0;
        repeat (8) tick();
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({btn_level, btn_press, btn_release, event_status} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_clear: got lvl=%b prs=%b rel=%b st=%h, want all 0",
                     btn_level, btn_press, btn_release, event_status);
        end
        @(negedge clk);
        tick();
        rst = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            vectors++;
            if (btn_press !== ((k == 11) ? 2'b11 : 2'b00)) begin
                miscompares++;
                $display("[TB] FAIL reset_mid_repress cycle %0d: got %b, want %b",
                         k, btn_press, (k == 11) ? 2'b11 : 2'b00);
            end
            vectors++;
            if ({btn_level, btn_press, btn_release, event_status} !== {mLevel, mPress, mRelease, mStatus}) begin
                miscompares++;
                $display("[TB] FAIL model_reset_mid cycle %0d: got %b %b %b %h, want %b %b %b %h", k,
                         btn_level, btn_press, btn_release, event_status, mLevel, mPress, mRelease, mStatus);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < NB; i++) holdLeft[i] = $urandom_range(1, 14);
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NB; i++) begin
                if (holdLeft[i] == 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    holdLeft[i] = $urandom_range(1, 14);
                end else begin
                    holdLeft[i] = holdLeft[i] - 1;
                end
            end
            event_clear = ($urandom_range(0, 5) == 0);
            event_clear_mask = NB'($urandom_range(0, 3));
            if (c == 400) rst = 1'b0;
            if (c == 403) rst = 1'b1;
            tick();
            vectors++;
            if ({btn_level, btn_press, btn_release, event_status} !== {mLevel, mPress, mRelease, mStatus}) begin
                miscompares++;
                $display("[TB] FAIL model_random cycle %0d: got %b %b %b %h, want %b %b %b %h", c,
                         btn_level, btn_press, btn_release, event_status, mLevel, mPress, mRelease, mStatus);
            end
        end
        event_clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
